ps2_mouse_tracker: RTL and testbench
====================================

# ps2_mouse_tracker

Consumes the byte stream from the PS/2 serial receiver and assembles standard 3-byte PS/2 mouse packets. It checks packet alignment, sign-extends the movement deltas, and accumulates a cursor position clamped to the 160x120 VGA grid. It also registers the button states. It sits between the PS/2 byte receiver and the cursor/drawing logic that drives `vga_adapter`.

## Interface
Parameters:
- `X_MAX`, 159: largest legal cursor X.
- `Y_MAX`, 119: largest legal cursor Y.
- `X_INIT`, 80: cursor X after reset.
- `Y_INIT`, 60: cursor Y after reset.
- `TIMEOUT_CYCLES`, 100000: inter-byte timeout in `clk` cycles (2 ms at 50 MHz).

Ports:
- `clk` in 1: system clock (CLOCK_50 domain).
- `reset` in 1: synchronous, active-high reset.
- `byte_in` in 8: received data byte, valid while `byte_valid`=1.
- `byte_valid` in 1: one-cycle strobe, one received byte.
- `byte_err` in 1: one-cycle strobe, receiver parity/framing error.
- `mouse_x` out 8: cursor X, 0..X_MAX.
- `mouse_y` out 7: cursor Y, 0..Y_MAX, origin top-left.
- `left_button` out 1: button state from the last committed packet.
- `right_button` out 1: button state from the last committed packet.
- `middle_button` out 1: button state from the last committed packet.
- `packet_valid` out 1: one-cycle pulse when a packet is committed.
- `sync_err` out 1: one-cycle pulse when a byte or packet is discarded.

## Operation
- FSM states: `WAIT_B0`, `WAIT_B1`, `WAIT_B2`, `UPDATE`.
- `WAIT_B0` with `byte_valid`:
  - If `byte_in[3]`=1: latch status byte, go to `WAIT_B1`.
  - Else: drop the byte, pulse `sync_err`, stay in `WAIT_B0`.
- Status byte fields: [0] L, [1] R, [2] M, [4] X sign, [5] Y sign, [6] X overflow, [7] Y overflow.
- `WAIT_B1` with `byte_valid`: latch dx low byte, go to `WAIT_B2`.
- `WAIT_B2` with `byte_valid`: latch dy low byte, go to `UPDATE`.
- `UPDATE` (one cycle): commit and return to `WAIT_B0`.
  - A `byte_valid` arriving in `UPDATE` is evaluated exactly as in `WAIT_B0`.
- Delta width:
  - dx = {Xsign, byte1}, 9-bit two's complement, range -256..255.
  - dy = {Ysign, byte2}, same format.
  - If an axis overflow bit is set, that axis delta is forced to 0.
- Commit arithmetic:
  - Computed in 11-bit signed.
  - x_new = clamp(mouse_x + dx, 0, X_MAX).
  - y_new = clamp(mouse_y − dy, 0, Y_MAX); PS/2 +Y is up.
  - Buttons load from the latched status byte.
  - All outputs change only at commit.
- `byte_err` in any state:
  - Discard any partial packet and go to `WAIT_B0`.
  - Pulse `sync_err` only if the state was `WAIT_B1` or `WAIT_B2`.
  - `byte_err` takes priority over a simultaneous `byte_valid`.
- Timeout:
  - The counter clears on every accepted byte and counts only in `WAIT_B1`/`WAIT_B2`.
  - On reaching TIMEOUT_CYCLES−1: go to `WAIT_B0` and pulse `sync_err`.
  - A `byte_valid` in the same cycle wins: the byte is accepted and the counter clears.
- Reset values:
  - `mouse_x`=X_INIT, `mouse_y`=Y_INIT.
  - All buttons 0; `packet_valid`=0, `sync_err`=0.
  - State `WAIT_B0`, timeout counter 0.
- Reset mid-packet: the partial packet is lost and no commit occurs.

## Timing
- Byte 2 `byte_valid` in cycle T:
  - State is `UPDATE` in T+1.
  - New `mouse_x`, `mouse_y` and buttons are visible in T+2.
  - `packet_valid`=1 in T+2 only.
- `sync_err` is high in the cycle after the offending strobe or timeout, for exactly one cycle.
- All outputs are registered; no combinational path from inputs to outputs.
- Sustained throughput: one byte per cycle, including a status byte arriving in `UPDATE`.

## Test plan
- Reset release with no traffic -> `mouse_x`=80, `mouse_y`=60, buttons 0, no pulses for 10 cycles.
- Bytes 0x08, 0x05, 0x03 from reset -> `mouse_x`=85, `mouse_y`=57, buttons 0; `packet_valid` exactly 2 cycles after the third strobe.
- Bytes 0x39, 0x9C, 0x80 from (80,60): dx=−100, dy=−128 -> `mouse_x`=0, `mouse_y`=119, `left_button`=1.
- Misalignment: byte 0x05 -> `sync_err` pulse, no commit; then 0x08, 0x02, 0x00 -> x+2, y unchanged.
- Timeout: bytes 0x08, 0x10, then idle TIMEOUT_CYCLES -> `sync_err`; then 0x08, 0x01, 0x00 -> x+1, not x+16.
- Overflow and error abort:
  - Bytes 0x48, 0xFF, 0x01 -> x unchanged, y−1.
  - Bytes 0x08, 0x04, then a `byte_err` strobe -> `sync_err`, no commit.
  - Next 0x08, 0x01, 0x01 -> x+1, y−1.

Source files
------------

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse packet assembler and cursor tracker.
// Frames 3-byte mouse packets from the receiver byte stream, sign-extends
// the deltas, and accumulates a cursor clamped to the VGA grid.
//
// state   | meaning
// --------+-------------------------------------------------------------
// WAIT_B0 | idle, waiting for a status byte (bit 3 set)
// WAIT_B1 | status latched, waiting for the X delta byte
// WAIT_B2 | X delta latched, waiting for the Y delta byte
// UPDATE  | full packet held; commit this cycle (also accepts a new status)
module ps2_mouse_tracker #(
    parameter int X_MAX          = 159,
    parameter int Y_MAX          = 119,
    parameter int X_INIT         = 80,
    parameter int Y_INIT         = 60,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       byte_err,
    output logic [7:0] mouse_x,
    output logic [6:0] mouse_y,
    output logic       left_button,
    output logic       right_button,
    output logic       middle_button,
    output logic       packet_valid,
    output logic       sync_err
);

    // Sized so TIMEOUT_CYCLES itself fits; the counter may step once past the
    // terminal value on the cycle the FSM leaves for WAIT_B0.
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, UPDATE} state_t;

    state_t        state, state_nx;
    logic [2:0]    btn_q;
    logic          x_sign_q, y_sign_q, x_ovf_q, y_ovf_q;
    logic [7:0]    dx_lo_q, dy_lo_q;
    logic [CW-1:0] tmo_cnt;

    logic latch_status, latch_dx, latch_dy;
    logic sync_err_nx, commit, in_packet, tmo_hit;

    logic signed [10:0] dx, dy, x_sum, y_sum;
    logic [7:0]         x_new;
    logic [6:0]         y_new;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= WAIT_B0;
        else       state <= state_nx;
    end

    // Next-state decode; byte_err overrides everything, a byte beats a timeout
    always_comb begin
        state_nx     = state;
        latch_status = 1'b0;
        latch_dx     = 1'b0;
        latch_dy     = 1'b0;
        sync_err_nx  = 1'b0;
        commit       = (state == UPDATE);
        in_packet    = (state == WAIT_B1) || (state == WAIT_B2);
        tmo_hit      = in_packet && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
        if (byte_err) begin
            state_nx    = WAIT_B0;
            sync_err_nx = in_packet;
        end else begin
            case (state)
                WAIT_B0, UPDATE: begin
                    state_nx = WAIT_B0;
                    if (byte_valid) begin
                        if (byte_in[3]) begin
                            latch_status = 1'b1;
                            state_nx     = WAIT_B1;
                        end else begin
                            sync_err_nx = 1'b1;
                        end
                    end
                end
                WAIT_B1: begin
                    if (byte_valid) begin
                        latch_dx = 1'b1;
                        state_nx = WAIT_B2;
                    end else if (tmo_hit) begin
                        state_nx    = WAIT_B0;
                        sync_err_nx = 1'b1;
                    end
                end
                WAIT_B2: begin
                    if (byte_valid) begin
                        latch_dy = 1'b1;
                        state_nx = UPDATE;
                    end else if (tmo_hit) begin
                        state_nx    = WAIT_B0;
                        sync_err_nx = 1'b1;
                    end
                end
                default: state_nx = WAIT_B0;
            endcase
        end
    end

    // Inter-byte timeout counter: runs only mid-packet, clears on each accepted byte
    always_ff @(posedge clk) begin
        if (reset)
            tmo_cnt <= '0;
        else if (latch_status || latch_dx || latch_dy || !in_packet)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Packet field capture
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q    <= '0;
            x_sign_q <= 1'b0;
            y_sign_q <= 1'b0;
            x_ovf_q  <= 1'b0;
            y_ovf_q  <= 1'b0;
            dx_lo_q  <= '0;
            dy_lo_q  <= '0;
        end else begin
            if (latch_status) begin
                btn_q    <= byte_in[2:0];
                x_sign_q <= byte_in[4];
                y_sign_q <= byte_in[5];
                x_ovf_q  <= byte_in[6];
                y_ovf_q  <= byte_in[7];
            end
            if (latch_dx) dx_lo_q <= byte_in;
            if (latch_dy) dy_lo_q <= byte_in;
        end
    end

    // Delta sign extension and clamped cursor arithmetic; PS/2 +Y points up
    always_comb begin
        dx    = x_ovf_q ? 11'sd0 : $signed({{3{x_sign_q}}, dx_lo_q});
        dy    = y_ovf_q ? 11'sd0 : $signed({{3{y_sign_q}}, dy_lo_q});
        x_sum = $signed({3'b000, mouse_x}) + dx;
        y_sum = $signed({4'b0000, mouse_y}) - dy;
        if (x_sum < 0)          x_new = 8'd0;
        else if (x_sum > X_MAX) x_new = 8'(X_MAX);
        else                    x_new = x_sum[7:0];
        if (y_sum < 0)          y_new = 7'd0;
        else if (y_sum > Y_MAX) y_new = 7'(Y_MAX);
        else                    y_new = y_sum[6:0];
    end

    // Registered outputs: cursor and buttons move only on commit
    always_ff @(posedge clk) begin
        if (reset) begin
            mouse_x       <= 8'(X_INIT);
            mouse_y       <= 7'(Y_INIT);
            left_button   <= 1'b0;
            right_button  <= 1'b0;
            middle_button <= 1'b0;
            packet_valid  <= 1'b0;
            sync_err      <= 1'b0;
        end else begin
            packet_valid <= commit;
            sync_err     <= sync_err_nx;
            if (commit) begin
                mouse_x       <= x_new;
                mouse_y       <= y_new;
                left_button   <= btn_q[0];
                right_button  <= btn_q[1];
                middle_button <= btn_q[2];
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Testbench for ps2_mouse_tracker: directed packets plus a randomized run,
// checked against an arithmetic model of cursor movement.
module tb_ps2_mouse_tracker;

    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_err = 1'b0;
    logic [7:0] mouse_x;
    logic [6:0] mouse_y;
    logic       left_button, right_button, middle_button;
    logic       packet_valid, sync_err;

    always #5 clk = ~clk;

    ps2_mouse_tracker #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_err(byte_err), .mouse_x(mouse_x), .mouse_y(mouse_y),
        .left_button(left_button), .right_button(right_button),
        .middle_button(middle_button), .packet_valid(packet_valid),
        .sync_err(sync_err)
    );

    typedef struct {int x; int y; logic [2:0] b;} exp_t;

    int   n_checks = 0, n_pass = 0, n_fail = 0;
    int   mx, my, n_model;
    exp_t q[$];
    int   pv_cnt = 0, se_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Cursor model: apply one committed packet with plain integer arithmetic
    task automatic model_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int dx, dy;
        dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
        dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
        mx = mx + dx;
        my = my - dy;
        if (mx < 0) mx = 0;
        if (mx > 159) mx = 159;
        if (my < 0) my = 0;
        if (my > 119) my = 119;
        q.push_back('{mx, my, b0[2:0]});
        n_model++;
    endtask

    // Commit monitor: every packet_valid must match the next modelled packet
    always @(negedge clk) begin : mon
        exp_t e;
        if (sync_err) se_cnt++;
        if (packet_valid) begin
            pv_cnt++;
            chk("commit_expected", (q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("mouse_x", mouse_x, e.x);
                chk("mouse_y", mouse_y, e.y);
                chk("buttons", {middle_button, right_button, left_button}, e.b);
            end
        end
    end

    // All drive tasks start and end 1 time unit after a rising edge
    task automatic send(input logic [7:0] b);
        byte_in = b;
        byte_valid = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        byte_in = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int gap);
        model_pkt(b0, b1, b2);
        send(b0); idle(gap);
        send(b1); idle(gap);
        send(b2);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        mx = 80; my = 60;
        q.delete();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int s0, pc, n_bad;
        logic [7:0] b0, b1, b2;
        n_model = 0;
        @(posedge clk); #1;
        do_reset();

        // reset state and quiet idle
        @(negedge clk);
        chk("rst_x", mouse_x, 80);
        chk("rst_y", mouse_y, 60);
        chk("rst_btn", {middle_button, right_button, left_button}, 0);
        @(posedge clk); #1;
        s0 = se_cnt; pc = pv_cnt;
        idle(10);
        chk("idle_sync_err", se_cnt, s0);
        chk("idle_commit", pv_cnt, pc);

        // basic packet with exact commit latency
        model_pkt(8'h08, 8'h05, 8'h03);
        send(8'h08); send(8'h05); send(8'h03);
        @(negedge clk); chk("pv_t1", packet_valid, 0);
        @(posedge clk); #1;
        @(negedge clk); chk("pv_t2", packet_valid, 1);
        chk("basic_x", mouse_x, 85);
        chk("basic_y", mouse_y, 57);
        @(posedge clk); #1;
        @(negedge clk); chk("pv_t3", packet_valid, 0);
        @(posedge clk); #1;

        // clamping on both axes from reset position
        do_reset();
        pkt(8'h39, 8'h9C, 8'h80, 0);
        idle(3);
        chk("clamp_x", mouse_x, 0);
        chk("clamp_y", mouse_y, 119);
        chk("clamp_left", left_button, 1);

        // misaligned byte then a good packet
        s0 = se_cnt; pc = pv_cnt;
        send(8'h05);
        @(negedge clk); chk("misalign_pulse", sync_err, 1);
        @(posedge clk); #1;
        @(negedge clk); chk("misalign_one_cycle", sync_err, 0);
        @(posedge clk); #1;
        chk("misalign_no_commit", pv_cnt, pc);
        pkt(8'h08, 8'h02, 8'h00, 0);
        idle(3);
        chk("realign_x", mouse_x, 2);
        chk("realign_y", mouse_y, 119);

        // timeout mid-packet discards the partial packet
        s0 = se_cnt; pc = pv_cnt;
        send(8'h08); send(8'h10);
        idle(TO + 2);
        chk("timeout_pulse", se_cnt, s0 + 1);
        chk("timeout_no_commit", pv_cnt, pc);
        pkt(8'h08, 8'h01, 8'h00, 0);
        idle(3);
        chk("after_timeout_x", mouse_x, 3);

        // a byte arriving in the terminal-count cycle wins over the timeout
        s0 = se_cnt;
        model_pkt(8'h08, 8'h02, 8'h00);
        send(8'h08); idle(TO - 1);
        send(8'h02); idle(TO - 1);
        send(8'h00);
        idle(3);
        chk("tc_boundary_no_err", se_cnt, s0);
        chk("tc_boundary_x", mouse_x, 5);

        // overflow forces X delta to zero
        pkt(8'h48, 8'hFF, 8'h01, 0);
        idle(3);
        chk("ovf_x", mouse_x, 5);
        chk("ovf_y", mouse_y, 118);

        // byte_err mid-packet aborts with sync_err
        s0 = se_cnt; pc = pv_cnt;
        send(8'h08); send(8'h04);
        byte_err = 1'b1;
        @(posedge clk); #1;
        byte_err = 1'b0;
        @(negedge clk); chk("err_pulse", sync_err, 1);
        @(posedge clk); #1;
        idle(3);
        chk("err_no_commit", pv_cnt, pc);
        // byte_err while idle is silent
        byte_err = 1'b1;
        @(posedge clk); #1;
        byte_err = 1'b0;
        idle(3);
        chk("err_idle_silent", se_cnt, s0 + 1);
        // byte_err beats a simultaneous byte_valid
        send(8'h08);
        byte_err = 1'b1; byte_in = 8'h50; byte_valid = 1'b1;
        @(posedge clk); #1;
        byte_err = 1'b0; byte_valid = 1'b0;
        idle(3);
        chk("err_priority_pulse", se_cnt, s0 + 2);
        pkt(8'h08, 8'h01, 8'h01, 0);
        idle(3);
        chk("err_recover_x", mouse_x, 6);
        chk("err_recover_y", mouse_y, 117);

        // randomized packets, back-to-back status in UPDATE and stray bytes
        s0 = se_cnt; n_bad = 0;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                send(8'($urandom) & 8'hF7);
                n_bad++;
            end else begin
                b0 = 8'($urandom) | 8'h08;
                b1 = 8'($urandom);
                b2 = 8'($urandom);
                pkt(b0, b1, b2, $urandom_range(0, 2));
            end
            idle($urandom_range(0, 1));
        end
        idle(5);
        chk("rand_sync_err", se_cnt, s0 + n_bad);
        chk("rand_queue_drained", q.size(), 0);
        chk("total_commits", pv_cnt, n_model);

        // reset mid-packet: partial packet lost, no commit
        pc = pv_cnt;
        send(8'h08); send(8'h05);
        do_reset();
        idle(5);
        chk("midreset_no_commit", pv_cnt, pc);
        chk("midreset_x", mouse_x, 80);
        pkt(8'h08, 8'h01, 8'h00, 0);
        idle(3);
        chk("midreset_fresh_x", mouse_x, 81);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
